// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with ACK check; `define PS2_TX_GLITCH_FILTER_EN adds a device-clock glitch filter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] idx_q, idx_d;
  logic par_q, par_d, bit_q, bit_d;
  logic [1:0] clk_sync_q, data_sync_q;
  logic clk_s, data_s, fe, nack, timeout;
  assign clk_s = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  // two-flop synchronisers for both pads; lines idle high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sync_q <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic armed_q;
  assign fe = armed_q & ~clk_s & ~|hist_q;
  // arm after four high samples, fire on the fourth consecutive low sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q <= 3'b111;
      armed_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], clk_s};
      armed_q <= fe ? 1'b0 : (clk_s & &hist_q) ? 1'b1 : armed_q;
    end
`else
  logic clk_p_q;
  assign fe = clk_p_q & ~clk_s;
  // previous synchronised clock for falling-edge detect
  always_ff @(posedge clk or posedge rst)
    if (rst) clk_p_q <= 1'b1;
    else clk_p_q <= clk_s;
`endif
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      par_q <= par_d;
      bit_q <= bit_d;
    end
  // next state: inhibit timing, one bit per device falling edge, abort on done/error
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    idx_d = idx_q;
    par_d = par_q;
    bit_d = bit_q;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        cnt_d = '0;
        sh_d = tx_data;
        par_d = ~^tx_data;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = REQ;
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = fe ? '0 : cnt_q + 1'b1;
        if (fe)
          case (state_q)
            REQ: begin
              bit_d = sh_q[0];
              idx_d = 4'd1;
              state_d = DATA;
            end
            DATA: begin
              bit_d = idx_q[3] ? par_q : sh_q[idx_q[2:0]];
              idx_d = idx_q + 4'd1;
              state_d = idx_q[3] ? PARITY : DATA;
            end
            PARITY: state_d = STOP;
            STOP: state_d = data_s ? IDLE : WAIT_IDLE;
            default: ;
          endcase
        if (done || timeout) state_d = IDLE;
      end
    endcase
  end
  // outputs: line drives and completion/error pulses decoded from state
  always_comb begin
    tx_ready = state_q == IDLE;
    busy = state_q != IDLE;
    ps2_clk_oe = state_q == INHIBIT;
    ps2_data_oe = (state_q == REQ) | (((state_q == DATA) | (state_q == PARITY)) & ~bit_q);
    nack = (state_q == STOP) & fe & data_s;
    done = (state_q == WAIT_IDLE) & clk_s & data_s;
    timeout = (state_q >= REQ) & ~fe & ~done & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    err = nack | timeout;
    err_code = {nack, timeout};
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with a PS/2 device model and frame reference for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO = 5000;
`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, clk_oe, data_oe, busy, done, err;
  logic [1:0] err_code;
  logic dev_clk = 1, dev_data = 1;
  logic ps2_clk_in, ps2_data_in;
  assign ps2_clk_in = dev_clk & ~clk_oe;
  assign ps2_data_in = dev_data & ~data_oe;
  int tests = 0, fails = 0, cyc = 0, last_fall = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, oe_cnt = 0, acc_cyc = 0, drop_cyc = 0, both_cnt = 0;
  logic [1:0] code_last = 0, post_oe = 0;
  logic post_ready = 0, err_p = 0, drop_pend = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
      code_last = err_code;
    end
    if (err_p) begin
      post_oe = {clk_oe, data_oe};
      post_ready = tx_ready;
    end
    err_p = err;
    if (clk_oe) oe_cnt++;
    if (done && err) both_cnt++;
    if (tx_valid && tx_ready) begin
      acc_cyc = cyc;
      drop_pend = 1;
    end else if (drop_pend && data_oe) begin
      drop_cyc = cyc;
      drop_pend = 0;
    end
  end

  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1;
    tick(1);
    tx_data = ~d;
    tick(3);
    tx_valid = 0;
  endtask

  task automatic device(input int n, input bit ack, input bit glitch, input int half,
                        output logic [9:0] got, output bit ok);
    ok = 0;
    got = '0;
    for (int k = 0; k < INH + 50; k++) begin
      tick(1);
      if (!clk_oe && data_oe) begin
        ok = 1;
        break;
      end
    end
    if (!ok) return;
    tick(20);
    for (int i = 0; i < n; i++) begin
      if (i == 10 && ack) dev_data = 0;
      dev_clk = 0;
      last_fall = cyc;
      tick(half);
      dev_clk = 1;
      if (glitch && i == 3) begin
        tick(half / 4);
        dev_clk = 0;
        tick(2);
        dev_clk = 1;
        tick(half / 4);
      end else tick(half / 2);
      if (i < 10) got[i] = ps2_data_in;
      tick(half / 2);
    end
    dev_data = 1;
  endtask

  task automatic test_reset;
    tick(3);
    tests++;
    if ({tx_ready, busy, done, err, err_code, clk_oe, data_oe} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_values got=%b exp=10000000", {tx_ready, busy, done, err, err_code, clk_oe, data_oe});
    end
    rst = 0;
    tick(10);
  endtask

  task automatic test_send_ed;
    logic [9:0] got;
    bit ok;
    int o0 = oe_cnt, d0 = done_cnt, e0 = err_cnt;
    start_tx(8'hED);
    device(11, 1, 0, 1000, got, ok);
    tick(10);
    tests++;
    if (!ok) begin fails++; $display("FAIL ed_request got=0 exp=1"); end
    tests++;
    if (got !== frame(8'hED)) begin fails++; $display("FAIL ed_bits got=%b exp=%b", got, frame(8'hED)); end
    tests++;
    if (oe_cnt - o0 != INH) begin fails++; $display("FAIL ed_inhibit got=%0d exp=%0d", oe_cnt - o0, INH); end
    tests++;
    if (drop_cyc - acc_cyc != INH + 1) begin fails++; $display("FAIL ed_latency got=%0d exp=%0d", drop_cyc - acc_cyc, INH + 1); end
    tests++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      fails++;
      $display("FAIL ed_done got done=%0d err=%0d exp done=1 err=0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_acked(input logic [7:0] d, input bit glitch, input string name);
    logic [9:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(d);
    device(11, 1, glitch, 100, got, ok);
    tick(10);
    tests++;
    if (!ok || got !== frame(d)) begin fails++; $display("FAIL %s_bits d=%h got=%b exp=%b", name, d, got, frame(d)); end
    tests++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      fails++;
      $display("FAIL %s_done got done=%0d err=%0d exp done=1 err=0", name, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_parity;
    test_acked(8'h01, 0, "par01");
    for (int i = 0; i < 3; i++) test_acked(8'($urandom_range(0, 255)), 0, "rand");
  endtask

  task automatic test_nack;
    logic [9:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(8'hFF);
    device(11, 0, 0, 100, got, ok);
    tick(5);
    tests++;
    if (err_cnt - e0 != 1 || code_last !== 2'b10 || done_cnt != d0) begin
      fails++;
      $display("FAIL nack_err got err=%0d code=%b done=%0d exp err=1 code=10 done=0", err_cnt - e0, code_last, done_cnt - d0);
    end
    tests++;
    if (post_oe !== 2'b00 || post_ready !== 1'b1) begin
      fails++;
      $display("FAIL nack_release got oe=%b ready=%b exp oe=00 ready=1", post_oe, post_ready);
    end
  endtask

  task automatic test_timeout;
    logic [9:0] got;
    bit ok;
    int e0 = err_cnt;
    start_tx(8'($urandom_range(0, 255)));
    device(4, 0, 0, 100, got, ok);
    for (int k = 0; k < TO + 200 && err_cnt == e0; k++) tick(1);
    tick(3);
    tests++;
    if (err_cnt - e0 != 1 || code_last !== 2'b01) begin
      fails++;
      $display("FAIL timeout_err got err=%0d code=%b exp err=1 code=01", err_cnt - e0, code_last);
    end
    tests++;
    if (err_cyc - last_fall != TO + LAT) begin
      fails++;
      $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - last_fall, TO + LAT);
    end
    tests++;
    if (post_oe !== 2'b00 || {clk_oe, data_oe} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_release got=%b exp=00", post_oe);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] got;
    bit ok;
    start_tx(8'h5A);
    tick(10);
    rst = 1;
    #1;
    tests++;
    if (clk_oe !== 1'b0) begin fails++; $display("FAIL rst_inhibit got=%b exp=0", clk_oe); end
    tick(2);
    rst = 0;
    tick(5);
    start_tx(8'h00);
    device(3, 0, 0, 100, got, ok);
    tick(5);
    tests++;
    if (!ok || data_oe !== 1'b1) begin fails++; $display("FAIL rst_pre got=%b exp=1", data_oe); end
    rst = 1;
    #1;
    tests++;
    if ({clk_oe, data_oe, tx_ready, busy} !== 4'b0010) begin
      fails++;
      $display("FAIL rst_async got=%b exp=0010", {clk_oe, data_oe, tx_ready, busy});
    end
    tick(2);
    rst = 0;
    tick(5);
    test_acked(8'hF4, 0, "after_rst");
  endtask

`ifdef PS2_TX_GLITCH_FILTER_EN
  task automatic test_glitch;
    test_acked(8'($urandom_range(0, 255)), 1, "glitch");
  endtask
`endif

  task automatic test_exclusive;
    tests++;
    if (both_cnt != 0) begin fails++; $display("FAIL exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_send_ed;
    test_parity;
    test_nack;
    test_timeout;
    test_reset_mid;
`ifdef PS2_TX_GLITCH_FILTER_EN
    test_glitch;
`endif
    test_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
